compute_job_dispatcher: RTL
===========================

Name: compute_job_dispatcher

Overview:
Parametrised successor to the single-kernel compute wrapper's start/idle sequencer. Accepts matrix-multiply job descriptors from the command-parsing box and queues them in an internal FIFO. Dispatches each job to one of NUM_KERNELS HLS kernel instances using the ap_start/ap_ready/ap_done/ap_idle handshake, and returns per-job completion records (work_id, kernel index) on a valid/ready stream toward the status FIFO.

Parameters:
NUM_KERNELS, 4, number of kernel instances served (1..16)
QUEUE_DEPTH, 8, job FIFO depth (power of 2, >=2)
ADDR_WIDTH, 64, base-address width driven to kernels
DIM_WIDTH, 32, width of a_row/a_col/b_col
ID_WIDTH, 32, work_id width

Ports:
axis_aclk  in  1  sole clock
axis_rst  in  1  synchronous active-high reset
job_valid  in  1  descriptor valid
job_ready  out  1  FIFO not full
job_a_base, job_b_base, job_c_base  in  ADDR_WIDTH each  matrix base addresses
job_a_row, job_a_col, job_b_col  in  DIM_WIDTH each  dimensions
job_work_id  in  ID_WIDTH  job tag
ker_a, ker_b, ker_c  out  ADDR_WIDTH each  shared argument bus
ker_a_row, ker_a_col, ker_b_col  out  DIM_WIDTH each  shared argument bus
ker_work_id  out  ID_WIDTH  shared argument bus
ker_arg_vld  out  NUM_KERNELS  one-hot 1-cycle argument-valid pulse
ker_start  out  NUM_KERNELS  ap_start per kernel
ker_ready  in  NUM_KERNELS  ap_ready per kernel
ker_done  in  NUM_KERNELS  ap_done per kernel (1-cycle pulse)
ker_idle  in  NUM_KERNELS  ap_idle per kernel
done_valid  out  1  completion record valid
done_ready  in  1  completion consumer ready
done_work_id  out  ID_WIDTH  completed job tag
done_kernel  out  $clog2(NUM_KERNELS) (min 1)  kernel that ran it
jobs_inflight  out  $clog2(NUM_KERNELS+1)  count of busy kernels

Behaviour:
- Reset: all outputs 0; FIFO empty; busy/pending/rr pointers 0; FSM IDLE. Reset mid-job abandons in-flight jobs; no completion is emitted for them.
- Job intake: a push occurs when job_valid && job_ready. job_ready = !full, registered from the count. A pop in the same cycle does not raise job_ready that cycle.
- Eligibility: kernel k is eligible iff ker_idle[k] && !busy[k] && !pending[k].
- FSM IDLE: if FIFO non-empty and any kernel is eligible, select k by round-robin starting at rr_ptr, pop the FIFO, drive the ker_* bus with the job, latch tag[k] <= work_id, go to ARGS.
- FSM ARGS (1 cycle): ker_arg_vld[k]=1; go to START.
- FSM START: hold ker_start[k]=1 until the cycle ker_ready[k]=1. That cycle: deassert start next, set busy[k], rr_ptr <= k+1 (mod NUM_KERNELS), return to IDLE.
- Argument bus is stable from the ARGS cycle through the ker_ready cycle. Minimum dispatch interval is 3 cycles.
- ker_done[k] with busy[k]: clear busy[k], set pending[k]. ker_done on a non-busy kernel is ignored. Done and start on different kernels in the same cycle are both honoured.
- Completion output: when no record is held, pick the lowest-index pending kernel at or after the completion rr pointer and register done_valid/done_work_id=tag[k]/done_kernel=k. Clear pending[k] on load.
- done_* hold stable while done_valid && !done_ready. After a handshake, the next record loads in the following cycle.
- pending blocks redispatch of a kernel, so one record per kernel at most; no overflow is possible.
- jobs_inflight = popcount(busy), registered.

Optional Feature:
DISPATCH_PERF_CNT_EN: adds outputs perf_jobs_done (32b, counts done handshakes) and perf_stall_cycles (32b, cycles with FIFO non-empty and no eligible kernel). Both counters saturate at all-ones and reset to 0. Without the macro these ports and counters are absent.

Decomposition:
- Package compute_dispatch_pkg: dispatch FSM state enum (IDLE/ARGS/START), job descriptor packed struct typedef, round-robin helper function.
- Sub-module: compute_job_fifo, a synchronous FIFO of descriptor structs with full/empty/count outputs.

Test Plan:
- 1 job (a=0x1000, b=0x2000, c=0x3000, dims 4/4/4, id=7), all kernels idle -> ker_arg_vld=0001, ker_start[0] held until ker_ready; done record id=7, kernel=0.
- 6 jobs back-to-back with NUM_KERNELS=4 and kernels never done -> kernels 0,1,2,3 started in order; 2 jobs remain queued; jobs_inflight=4.
- Push 9 jobs with QUEUE_DEPTH=8 and all kernels non-idle -> job_ready low after 8th push; 9th accepted only after one pop.
- ker_done on kernels 1 and 2 in the same cycle with done_ready=0 for 5 cycles -> kernel 1 record held stable, then kernel 2; neither kernel is redispatched until its record is drained.
- ker_ready delayed 4 cycles -> ker_start and argument bus stable for all 4 cycles.
- axis_rst asserted during START -> all outputs 0 next cycle; FIFO empty; no done_valid afterwards.

Source files
------------

// File: rtl/compute_dispatch_pkg.sv
// Shared types for the compute job dispatcher: FSM states, job descriptor, round-robin pick.
package compute_dispatch_pkg;

  localparam int JOB_ADDR_W  = 64;
  localparam int JOB_DIM_W   = 32;
  localparam int JOB_ID_W    = 32;
  localparam int MAX_KERNELS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARGS  = 2'd1,
    START = 2'd2
  } disp_state_t;

  typedef struct packed {
    logic [JOB_ADDR_W-1:0] a_base;
    logic [JOB_ADDR_W-1:0] b_base;
    logic [JOB_ADDR_W-1:0] c_base;
    logic [JOB_DIM_W-1:0]  a_row;
    logic [JOB_DIM_W-1:0]  a_col;
    logic [JOB_DIM_W-1:0]  b_col;
    logic [JOB_ID_W-1:0]   work_id;
  } job_desc_t;

  // First set bit of mask at or after start, wrapping modulo n; 0 when mask is empty.
  function automatic logic [3:0] rr_pick(input logic [MAX_KERNELS-1:0] mask,
                                         input logic [3:0] start,
                                         input logic [4:0] n);
    logic [3:0] pick;
    logic       found;
    logic [4:0] cand;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_KERNELS; i++) begin
      cand = {1'b0, start} + 5'(i);
      if (cand >= n) cand = cand - n;
      if (!found && (5'(i) < n) && mask[cand[3:0]]) begin
        pick  = cand[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/compute_job_fifo.sv
// Synchronous FIFO of job descriptors with first-word-fall-through head and occupancy count.
module compute_job_fifo
  import compute_dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          axis_aclk,
  input  logic          axis_rst,
  input  logic          push,
  input  job_desc_t     push_data,
  input  logic          pop,
  output job_desc_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  job_desc_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/compute_job_dispatcher.sv
// Queues matrix-multiply jobs and dispatches them round-robin to HLS kernels via ap_* handshakes.
// Optional macro DISPATCH_PERF_CNT_EN adds saturating done/stall performance counters.
module compute_job_dispatcher
  import compute_dispatch_pkg::*;
#(
  parameter int NUM_KERNELS = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int ADDR_WIDTH  = 64,
  parameter int DIM_WIDTH   = 32,
  parameter int ID_WIDTH    = 32,
  localparam int KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int IW = $clog2(NUM_KERNELS + 1)
) (
  input  logic                   axis_aclk,
  input  logic                   axis_rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [ADDR_WIDTH-1:0]  job_a_base,
  input  logic [ADDR_WIDTH-1:0]  job_b_base,
  input  logic [ADDR_WIDTH-1:0]  job_c_base,
  input  logic [DIM_WIDTH-1:0]   job_a_row,
  input  logic [DIM_WIDTH-1:0]   job_a_col,
  input  logic [DIM_WIDTH-1:0]   job_b_col,
  input  logic [ID_WIDTH-1:0]    job_work_id,
  output logic [ADDR_WIDTH-1:0]  ker_a,
  output logic [ADDR_WIDTH-1:0]  ker_b,
  output logic [ADDR_WIDTH-1:0]  ker_c,
  output logic [DIM_WIDTH-1:0]   ker_a_row,
  output logic [DIM_WIDTH-1:0]   ker_a_col,
  output logic [DIM_WIDTH-1:0]   ker_b_col,
  output logic [ID_WIDTH-1:0]    ker_work_id,
  output logic [NUM_KERNELS-1:0] ker_arg_vld,
  output logic [NUM_KERNELS-1:0] ker_start,
  input  logic [NUM_KERNELS-1:0] ker_ready,
  input  logic [NUM_KERNELS-1:0] ker_done,
  input  logic [NUM_KERNELS-1:0] ker_idle,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [ID_WIDTH-1:0]    done_work_id,
  output logic [KW-1:0]          done_kernel,
  output logic [IW-1:0]          jobs_inflight
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_jobs_done,
  output logic [31:0]            perf_stall_cycles
`endif
);

  localparam int            CW     = $clog2(QUEUE_DEPTH + 1);
  localparam logic [KW-1:0] LAST_K = KW'(NUM_KERNELS - 1);

  disp_state_t            state, state_nxt;
  job_desc_t              push_desc, head_desc, cur_desc;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count, count_nxt;
  logic                   push, pop, start_fire, rec_load;
  logic [NUM_KERNELS-1:0] busy, pending, busy_nxt, pending_nxt;
  logic [NUM_KERNELS-1:0] eligible, sel_oh, done_set, start_ack, rec_clr, held;
  logic [KW-1:0]          sel, pick_k, rr_ptr, cmp_ptr, cmp_k;
  logic [ID_WIDTH-1:0]    tag [NUM_KERNELS];

  assign push = job_valid && job_ready;

  always_comb begin
    push_desc         = '0;
    push_desc.a_base  = JOB_ADDR_W'(job_a_base);
    push_desc.b_base  = JOB_ADDR_W'(job_b_base);
    push_desc.c_base  = JOB_ADDR_W'(job_c_base);
    push_desc.a_row   = JOB_DIM_W'(job_a_row);
    push_desc.a_col   = JOB_DIM_W'(job_a_col);
    push_desc.b_col   = JOB_DIM_W'(job_b_col);
    push_desc.work_id = JOB_ID_W'(job_work_id);
  end

  compute_job_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .axis_aclk (axis_aclk),
    .axis_rst  (axis_rst),
    .push      (push),
    .push_data (push_desc),
    .pop       (pop),
    .head      (head_desc),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A kernel whose record still sits in the output register stays blocked until handed off.
  assign held     = done_valid ? (NUM_KERNELS'(1) << done_kernel) : '0;
  assign eligible = ker_idle & ~busy & ~pending & ~held;
  assign sel_oh   = NUM_KERNELS'(1) << sel;
  assign pick_k   = KW'(rr_pick(MAX_KERNELS'(eligible), 4'(rr_ptr), 5'(NUM_KERNELS)));
  assign cmp_k    = KW'(rr_pick(MAX_KERNELS'(pending), 4'(cmp_ptr), 5'(NUM_KERNELS)));

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    start_fire  = 1'b0;
    ker_arg_vld = '0;
    ker_start   = '0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && (|eligible)) begin
          pop       = 1'b1;
          state_nxt = ARGS;
        end
      end
      ARGS: begin
        ker_arg_vld = sel_oh;
        state_nxt   = START;
      end
      START: begin
        ker_start = sel_oh;
        if (ker_ready[sel]) begin
          start_fire = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign start_ack   = start_fire ? sel_oh : '0;
  assign done_set    = ker_done & busy;
  assign rec_load    = !done_valid && (|pending);
  assign rec_clr     = rec_load ? (NUM_KERNELS'(1) << cmp_k) : '0;
  assign busy_nxt    = (busy & ~done_set) | start_ack;
  assign pending_nxt = (pending | done_set) & ~rec_clr;
  assign count_nxt   = fifo_count + CW'(push) - CW'(pop);

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      busy          <= '0;
      pending       <= '0;
      rr_ptr        <= '0;
      cmp_ptr       <= '0;
      sel           <= '0;
      cur_desc      <= '0;
      job_ready     <= 1'b0;
      jobs_inflight <= '0;
      done_valid    <= 1'b0;
      done_work_id  <= '0;
      done_kernel   <= '0;
    end else begin
      busy          <= busy_nxt;
      pending       <= pending_nxt;
      job_ready     <= (count_nxt != CW'(QUEUE_DEPTH));
      jobs_inflight <= IW'($countones(busy_nxt));
      if (pop) begin
        sel      <= pick_k;
        cur_desc <= head_desc;
      end
      if (start_fire) rr_ptr <= (sel == LAST_K) ? '0 : sel + KW'(1);
      if (done_valid && done_ready) begin
        done_valid <= 1'b0;
      end else if (rec_load) begin
        done_valid   <= 1'b1;
        done_work_id <= tag[cmp_k];
        done_kernel  <= cmp_k;
        cmp_ptr      <= (cmp_k == LAST_K) ? '0 : cmp_k + KW'(1);
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (pop) tag[pick_k] <= ID_WIDTH'(head_desc.work_id);
  end

  assign ker_a       = ADDR_WIDTH'(cur_desc.a_base);
  assign ker_b       = ADDR_WIDTH'(cur_desc.b_base);
  assign ker_c       = ADDR_WIDTH'(cur_desc.c_base);
  assign ker_a_row   = DIM_WIDTH'(cur_desc.a_row);
  assign ker_a_col   = DIM_WIDTH'(cur_desc.a_col);
  assign ker_b_col   = DIM_WIDTH'(cur_desc.b_col);
  assign ker_work_id = ID_WIDTH'(cur_desc.work_id);

`ifdef DISPATCH_PERF_CNT_EN
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      perf_jobs_done    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (done_valid && done_ready && (perf_jobs_done != '1))
        perf_jobs_done <= perf_jobs_done + 32'd1;
      if (!fifo_empty && !(|eligible) && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
